// File: rtl/dword_feeder_if.sv
`default_nettype none
// ============================================================================
// dword_feeder_if : host byte stream in, dword strobes and status pulses out
// Rev 1.0
// ============================================================================
interface dword_feeder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy;
  logic        wr;
  logic [31:0] data_to_if;
  logic        len_error;
  logic        timeout_error;
  logic        frame_done;

  // master = the feeder, slave = host byte source plus downstream dword sink
  modport master (
    input  rx_data, rx_valid, busy,
    output rx_ready, wr, data_to_if, len_error, timeout_error, frame_done
  );
  modport slave (
    output rx_data, rx_valid, busy,
    input  rx_ready, wr, data_to_if, len_error, timeout_error, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/dword_feeder.sv
`default_nettype none
// ============================================================================
// dword_feeder : packs host bytes into little-endian dwords, header + payload
// Rev 1.0
// ============================================================================
module dword_feeder #(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 62500
) (
  input  logic           clk_in,
  input  logic           reset,
  dword_feeder_if.master bus
);
  localparam int                  c_timer_w  = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]          c_max_len  = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HDR       = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_PAY       = 3'd2,
    S_PAD       = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t                r_state;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_bytes;
  logic [31:0]           r_header;
  logic [9:0]            r_count;
  logic [c_timer_w-1:0]  r_timer;
  logic                  r_wr;
  logic [31:0]           r_data;
  logic                  r_len_error;
  logic                  r_timeout_error;
  logic                  r_frame_done;

  logic        w_rx_ready;
  logic        w_accept;
  logic        w_last_byte;
  logic [31:0] w_dword;
  logic [7:0]  w_len;
  logic        w_timer_on;
  logic        w_timeout;

  assign w_rx_ready  = (r_state == S_HDR) || (r_state == S_PAY) || (r_state == S_DRAIN);
  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_last_byte = w_accept && (r_byte_idx == 2'd3);
  assign w_dword     = {bus.rx_data, r_bytes};
  assign w_len       = r_bytes[15:8];
  assign w_timer_on  = ((r_state == S_HDR) && (r_byte_idx != 2'd0)) ||
                       (r_state == S_PAY) || (r_state == S_DRAIN);
  // An accepted byte on the terminal count cycle suppresses the timeout.
  assign w_timeout   = w_timer_on && !w_accept && (r_timer == c_timer_max);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state         <= S_HDR;
      r_byte_idx      <= 2'd0;
      r_bytes         <= 24'd0;
      r_header        <= 32'd0;
      r_count         <= 10'd0;
      r_timer         <= '0;
      r_wr            <= 1'b0;
      r_data          <= 32'd0;
      r_len_error     <= 1'b0;
      r_timeout_error <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_wr            <= 1'b0;
      r_len_error     <= 1'b0;
      r_timeout_error <= 1'b0;
      r_frame_done    <= 1'b0;

      if (w_timer_on && !w_accept) r_timer <= r_timer + 1'b1;
      else                         r_timer <= '0;

      if (w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_bytes[7:0]   <= bus.rx_data;
          2'd1:    r_bytes[15:8]  <= bus.rx_data;
          2'd2:    r_bytes[23:16] <= bus.rx_data;
          default: ;
        endcase
      end

      case (r_state)
        S_HDR: begin
          if (w_timeout) begin
            r_timeout_error <= 1'b1;
            r_byte_idx      <= 2'd0;
            r_timer         <= '0;
          end else if (w_last_byte) begin
            r_header <= w_dword;
            if ({1'b0, w_len} > c_max_len) begin
              r_len_error <= 1'b1;
              r_count     <= {w_len, 2'b00};
              r_state     <= S_DRAIN;
            end else begin
              r_count <= {2'b00, w_len};
              r_state <= S_WAIT_IDLE;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (!bus.busy) begin
            r_wr   <= 1'b1;
            r_data <= r_header;
            if (r_count == 10'd0) begin
              r_frame_done <= 1'b1;
              r_state      <= S_HDR;
            end else begin
              r_state <= S_PAY;
            end
          end
        end

        S_PAY: begin
          if (w_timeout) begin
            r_timeout_error <= 1'b1;
            r_byte_idx      <= 2'd0;
            r_timer         <= '0;
            r_state         <= S_PAD;
          end else if (w_last_byte) begin
            r_wr    <= 1'b1;
            r_data  <= w_dword;
            r_count <= r_count - 10'd1;
            if (r_count == 10'd1) begin
              r_frame_done <= 1'b1;
              r_state      <= S_HDR;
            end
          end
        end

        // Zero-fill so the downstream payload collector always completes.
        S_PAD: begin
          r_wr    <= 1'b1;
          r_data  <= 32'd0;
          r_count <= r_count - 10'd1;
          if (r_count == 10'd1) begin
            r_frame_done <= 1'b1;
            r_state      <= S_HDR;
          end
        end

        S_DRAIN: begin
          if (w_timeout) begin
            r_timeout_error <= 1'b1;
            r_byte_idx      <= 2'd0;
            r_timer         <= '0;
            r_state         <= S_HDR;
          end else if (w_accept) begin
            r_count <= r_count - 10'd1;
            if (r_count == 10'd1) r_state <= S_HDR;
          end
        end

        default: r_state <= S_HDR;
      endcase
    end
  end

  assign bus.rx_ready      = w_rx_ready;
  assign bus.wr            = r_wr;
  assign bus.data_to_if    = r_data;
  assign bus.len_error     = r_len_error;
  assign bus.timeout_error = r_timeout_error;
  assign bus.frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dword_feeder.sv
`default_nettype none
// ============================================================================
// tb_dword_feeder : directed vectors for dword_feeder
// Rev 1.0
// ============================================================================
module tb_dword_feeder;
  localparam int MAX_LEN        = 64;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  dword_feeder_if bus ();

  dword_feeder #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Event log of everything the DUT emits, sampled 1 time unit after each edge
  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  int          cyc       = 0;
  int          n_fd      = 0;
  int          n_fd_lone = 0;
  int          n_len_err = 0;
  int          n_to_err  = 0;

  always @(posedge clk_in) begin
    cyc++;
    #1;
    if (bus.wr) begin
      wr_q.push_back(bus.data_to_if);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.frame_done) begin
      n_fd++;
      if (!bus.wr) n_fd_lone++;
    end
    if (bus.len_error)     n_len_err++;
    if (bus.timeout_error) n_to_err++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc_q.delete();
    n_fd      = 0;
    n_fd_lone = 0;
    n_len_err = 0;
    n_to_err  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk_in);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && waited < 200) begin
      @(negedge clk_in);
      waited++;
    end
    if (!bus.rx_ready) check_val("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_dword(input logic [31:0] d);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    @(negedge clk_in);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.busy     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_val("reset_pulses", {28'd0, bus.wr, bus.len_error, bus.timeout_error, bus.frame_done}, 32'd0);
    check_val("reset_data", bus.data_to_if, 32'd0);
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    check_val("post_reset_ready", {31'd0, bus.rx_ready}, 32'd1);
    check_val("post_reset_wr", {31'd0, bus.wr}, 32'd0);

    // Basic frame
    clear_mon();
    send_dword(32'h0001_0202);
    send_dword(32'hDDCC_BBAA);
    send_dword(32'h4433_2211);
    idle(4);
    check_val("basic_count", wr_q.size(), 32'd3);
    check_val("basic_hdr", q_at(0), 32'h0001_0202);
    check_val("basic_pay0", q_at(1), 32'hDDCC_BBAA);
    check_val("basic_pay1", q_at(2), 32'h4433_2211);
    check_val("basic_done", n_fd, 32'd1);
    check_val("basic_done_with_wr", n_fd_lone, 32'd0);

    // Header gating on busy
    clear_mon();
    bus.busy = 1'b1;
    send_dword(32'h0000_0005);
    idle(20);
    check_val("gate_no_wr", wr_q.size(), 32'd0);
    check_val("gate_not_ready", {31'd0, bus.rx_ready}, 32'd0);
    @(negedge clk_in);
    bus.busy = 1'b0;
    @(posedge clk_in);
    #1;
    check_val("gate_wr", {31'd0, bus.wr}, 32'd1);
    check_val("gate_data", bus.data_to_if, 32'h0000_0005);
    check_val("gate_done", {31'd0, bus.frame_done}, 32'd1);
    @(posedge clk_in);
    #1;
    check_val("gate_wr_single", {31'd0, bus.wr}, 32'd0);

    // Over-long command, drained, then a normal frame
    clear_mon();
    send_dword(32'h0000_4107);
    idle(1);
    check_val("long_len_error", n_len_err, 32'd1);
    for (int i = 0; i < 260; i++) send_byte(8'(i));
    idle(2);
    check_val("long_no_wr", wr_q.size(), 32'd0);
    check_val("long_ready_after", {31'd0, bus.rx_ready}, 32'd1);
    send_dword(32'h0000_0109);
    send_dword(32'h0403_0201);
    idle(3);
    check_val("long_next_count", wr_q.size(), 32'd2);
    check_val("long_next_hdr", q_at(0), 32'h0000_0109);
    check_val("long_next_pay", q_at(1), 32'h0403_0201);
    check_val("long_next_len_error", n_len_err, 32'd1);

    // Length exactly MAX_LEN is accepted
    clear_mon();
    send_dword(32'h0000_400A);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    idle(3);
    check_val("max_count", wr_q.size(), 32'd65);
    check_val("max_len_error", n_len_err, 32'd0);
    check_val("max_first", q_at(1), 32'h0302_0100);
    check_val("max_last", q_at(64), 32'hFFFE_FDFC);
    check_val("max_done", n_fd, 32'd1);

    // Stall in payload -> timeout and zero padding
    clear_mon();
    send_dword(32'h0000_030B);
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
    idle(40);
    check_val("stall_count", wr_q.size(), 32'd4);
    check_val("stall_pay", q_at(1), 32'h1312_1110);
    check_val("stall_pad0", q_at(2), 32'd0);
    check_val("stall_pad1", q_at(3), 32'd0);
    check_val("stall_timeout", n_to_err, 32'd1);
    check_val("stall_done", n_fd, 32'd1);
    check_val("stall_done_with_wr", n_fd_lone, 32'd0);
    check_val("stall_pad_gap", (wr_cyc_q.size() >= 4) ? (wr_cyc_q[3] - wr_cyc_q[2]) : -1, 32'd1);

    // Byte arriving exactly on the timeout cycle wins
    clear_mon();
    send_byte(8'h21);
    idle(TIMEOUT_CYCLES - 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(4);
    check_val("edge_no_timeout", n_to_err, 32'd0);
    check_val("edge_count", wr_q.size(), 32'd1);
    check_val("edge_hdr", q_at(0), 32'h0000_0021);

    // One cycle longer does time out, and the partial header is dropped
    clear_mon();
    send_byte(8'h55);
    idle(TIMEOUT_CYCLES + 4);
    check_val("hdr_timeout", n_to_err, 32'd1);
    send_dword(32'h0000_0033);
    idle(4);
    check_val("hdr_timeout_next", q_at(0), 32'h0000_0033);
    check_val("hdr_timeout_wr_count", wr_q.size(), 32'd1);

    // Asynchronous reset mid-payload
    clear_mon();
    send_dword(32'h0000_020C);
    send_dword(32'h8765_4321);
    send_byte(8'h99);
    send_byte(8'h98);
    check_val("rst_pre_data", bus.data_to_if, 32'h8765_4321);
    #2;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    check_val("rst_async_pulses", {28'd0, bus.wr, bus.len_error, bus.timeout_error, bus.frame_done}, 32'd0);
    check_val("rst_async_data", bus.data_to_if, 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    clear_mon();
    send_dword(32'h0000_000D);
    idle(4);
    check_val("rst_fresh_count", wr_q.size(), 32'd1);
    check_val("rst_fresh_hdr", q_at(0), 32'h0000_000D);
    check_val("rst_fresh_done", n_fd, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dword_feeder.md
# dword_feeder

Upstream stage for `dword_interface`. Packs a host byte stream (UART/USB FIFO, valid/ready) into little-endian 32-bit dwords. Emits one header dword, then the header-specified number of payload dwords, as single-cycle `wr` pulses. Holds each header until the downstream `busy` is low, rejects over-long commands, and recovers from stalled host transfers with a timeout.

## Interface
- `MAX_LEN`, default 64: largest legal payload length in dwords. 64×32 = 2048 bits, which fits the 259-byte downstream buffer.
- `TIMEOUT_CYCLES`, default 62500: idle cycles allowed inside a partially received frame (1 ms at 62.5 MHz). Must be ≥ 2.
- `clk_in  input  1`: single clock; all logic on its rising edge.
- `reset  input  1`: asynchronous, active-high.
- `rx_data  input  8`: host byte.
- `rx_valid  input  1`: `rx_data` is valid.
- `rx_ready  output  1`: feeder can accept a byte. A byte transfers on a rising edge where `rx_valid && rx_ready`.
- `busy  input  1`: from `dword_interface`; registered there.
- `wr  output  1`: one-cycle dword strobe to `dword_interface`.
- `data_to_if  output  32`: dword presented with `wr`. Valid only while `wr` = 1.
- `len_error  output  1`: one-cycle pulse; header length > `MAX_LEN`.
- `timeout_error  output  1`: one-cycle pulse; stalled frame aborted.
- `frame_done  output  1`: one-cycle pulse; last dword of a frame (header-only or payload) issued.

## Operation
- **Byte order**
  - Byte k of a dword (k = 0..3) lands in bits [8k+7:8k].
  - A 2-bit byte index counts accepted bytes and wraps 3→0.
- **Header fields**
  - bits [7:0] = cmd
  - bits [15:8] = len (payload dwords)
  - bit 16 = quad
  - bits [31:17] are passed through unchanged.
- **States**: HDR, WAIT_IDLE, PAY, PAD, DRAIN.
- **HDR**
  - `rx_ready` = 1.
  - On the 4th byte: latch the header. Go to DRAIN if len > `MAX_LEN`, otherwise go to WAIT_IDLE.
  - A rejected header pulses `len_error` on the same edge and issues no `wr`.
- **WAIT_IDLE**
  - `rx_ready` = 0.
  - On the first edge where `busy` = 0 is sampled: `wr` ← 1, `data_to_if` ← header.
  - Then go to PAY if len > 0. If len = 0, pulse `frame_done` and go to HDR.
  - No timeout in this state.
- **PAY**
  - `rx_ready` = 1.
  - On each 4th byte: `wr` ← 1, `data_to_if` ← assembled dword, remaining count decrements.
  - When the count reaches 0: pulse `frame_done` and go to HDR.
  - `busy` is ignored in PAY, because downstream stays busy for the whole payload.
- **PAD**
  - `rx_ready` = 0.
  - Issues `wr` = 1 with `data_to_if` = 0 on consecutive cycles, once per remaining dword (including the discarded partial one).
  - Then pulses `frame_done` and goes to HDR. This keeps the downstream from hanging in payload collection.
- **DRAIN**
  - `rx_ready` = 1.
  - Discards len×4 bytes, then goes to HDR.
- **Timeout counter**
  - Active in HDR with byte index ≠ 0, in PAY, and in DRAIN.
  - Cleared on every accepted byte and on every state change.
  - Fires when it reaches `TIMEOUT_CYCLES`−1 in a cycle with no byte accepted. If a byte is accepted in that same cycle, the byte wins.
  - On fire: pulse `timeout_error`, clear the byte index, and then:
    - HDR: stay in HDR (partial header discarded).
    - PAY: go to PAD.
    - DRAIN: go to HDR.
- **Reset** (asynchronous, including mid-frame)
  - State = HDR, byte index = 0, counters = 0.
  - `wr`, `len_error`, `timeout_error`, `frame_done` = 0; `data_to_if` = 0; `rx_ready` = 1 after release.
  - The partial frame is lost; the downstream is reset by the same `reset`.

## Timing
- All outputs are registered, except `rx_ready`, which is decoded from state.
- **Header latency**: if `busy` = 0 is already sampled, the 4th header byte is accepted at edge N and `wr` is high from edge N+1 to N+2.
- **Payload latency**: the 4th payload byte is accepted at edge M and `wr` is high from M to M+1.
- **Payload rate**: at most one payload `wr` per 4 cycles; PAD issues one `wr` per cycle.
- **Back-to-back frames**: the next header's WAIT_IDLE starts at least one cycle after any `wr`. The downstream registered `busy` is therefore already 1 when sampled, so no double-issue can occur.
- `frame_done` coincides with the final `wr` of its frame.

## Test plan
- **Basic frame**: `busy` = 0, bytes 02 02 01 00, AA BB CC DD, 11 22 33 44 → three `wr` pulses:
  - 0x00010202
  - 0xDDCCBBAA
  - 0x44332211
  - `frame_done` with the last pulse.
- **Header gating**: hold `busy` = 1 for 20 cycles after a 4-byte header with len 0 → no `wr`, `rx_ready` = 0. Release `busy` → `wr` exactly one cycle later with `frame_done`.
- **Over-long command**: header len = 65 (0x41) → `len_error` pulse, no `wr`. The next 260 bytes are discarded, and the following header is processed normally.
- **Stall in payload**: `TIMEOUT_CYCLES` = 16, len = 3, send 6 payload bytes then stop → one data `wr`, then `timeout_error`, then two consecutive `wr` with data 0 and `frame_done`.
- **Timeout boundary**: partial header, then a byte arrives exactly on the timeout cycle → no `timeout_error`, and the byte is kept.
- **Reset mid-payload**: assert `reset` asynchronously mid-payload → all outputs 0 immediately. After release, a fresh header is assembled from byte index 0.
